if_prefetch_unit: RTL

//  Parametrised instruction-fetch stage for the 5-stage RV32 core. Issues pipelined

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fifo.sv | 57 +++++
 rtl/if_prefetch_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared defaults and types for the RV32 instruction-fetch stage.
package if_pkg;

  localparam int IF_XLEN = 32;
  localparam logic [IF_XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush; head word is readable combinationally once written.
module if_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = 2 * IF_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_pop_ok  = pop && (r_count != '0);
  assign w_push_ok = push && ((r_count != FULL_CNT) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign empty     = (r_count == '0);
  assign count     = r_count;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: pipelined IM reads, prefetch FIFO toward ID, redirect flush.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_flush_cnt counters.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN       = IF_XLEN,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = IF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            im_req_valid,
  input  logic            im_req_ready,
  output logic [XLEN-1:0] im_req_addr,
  input  logic            im_rsp_valid,
  input  logic [XLEN-1:0] im_rsp_data,
  input  logic            jb_valid,
  input  logic [XLEN-1:0] jb_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            wfi,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] epc_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [CW-1:0]     r_drop_cnt;
  logic              w_redirect;
  logic [XLEN-1:0]   w_target;
  logic              w_accept;
  logic              w_rsp_fire;
  logic              w_rsp_keep;
  logic [CW-1:0]     w_occupancy;
  logic [CW-1:0]     w_outstanding;
  logic [CW:0]       w_inflight;
  logic [XLEN-1:0]   w_rsp_pc;
  logic              w_aq_empty;
  logic              w_fifo_empty;
  logic [2*XLEN-1:0] w_head;
  logic              w_pop;

  assign w_redirect = trap_valid | jb_valid;
  assign w_target   = trap_valid ? {trap_addr[XLEN-1:2], 2'b00} : {jb_addr[XLEN-1:2], 2'b00};

  // Reserve a FIFO slot for every read in flight so responses never overflow.
  assign w_inflight   = (CW + 1)'(w_occupancy) + (CW + 1)'(w_outstanding);
  assign im_req_valid = !rst && !wfi && (w_inflight < DEPTH_C);
  assign im_req_addr  = w_redirect ? w_target : r_fetch_pc;
  assign w_accept     = im_req_valid && im_req_ready;

  // Responses with no tracked address are bus protocol errors and are ignored.
  assign w_rsp_fire = im_rsp_valid && !w_aq_empty;
  assign w_rsp_keep = w_rsp_fire && !w_redirect && (r_drop_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_accept) begin
      r_fetch_pc <= im_req_addr + XLEN'(4);
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
    end
  end

  // Everything already in flight at a redirect belongs to the old path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_redirect) begin
      r_drop_cnt <= w_outstanding - CW'(w_rsp_fire);
    end else if (w_rsp_fire && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  // Address-tracking queue: its occupancy is the outstanding-read count.
  if_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (w_accept),
    .push_data (im_req_addr),
    .pop       (w_rsp_fire),
    .head_data (w_rsp_pc),
    .empty     (w_aq_empty),
    .count     (w_outstanding)
  );

  if_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (w_redirect),
    .push      (w_rsp_keep),
    .push_data ({w_rsp_pc, im_rsp_data}),
    .pop       (w_pop),
    .head_data (w_head),
    .empty     (w_fifo_empty),
    .count     (w_occupancy)
  );

  assign id_valid = !w_fifo_empty;
  assign w_pop    = id_valid && id_ready;
  assign id_pc    = id_valid ? w_head[2*XLEN-1:XLEN] : '0;
  assign id_instr = id_valid ? w_head[XLEN-1:0] : '0;
  assign epc_out  = jb_valid ? jb_addr : (id_valid ? id_pc : r_fetch_pc);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_accept && (r_perf_fetch_cnt != '1))   r_perf_fetch_cnt <= r_perf_fetch_cnt + 1'b1;
      if (w_redirect && (r_perf_flush_cnt != '1)) r_perf_flush_cnt <= r_perf_flush_cnt + 1'b1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
